coin_collector: RTL and testbench

COIN_COLLECTOR -- requirements
Module: coin_collector

---
 rtl/coin_collector.sv | 160 ++++++++++++++++
 tb/tb_coin_collector.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_collector.sv
// Coin collector front-end for a vending machine: counts coins, issues items, refunds.
// Optional COIN_TIMEOUT_EN: refund automatically after TIMEOUT_CYCLES idle cycles in COLLECT.
module coin_collector #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coinValid,
    input  logic [1:0] coinType,
    input  logic       itemSelValid,
    input  logic [1:0] itemSel,
    input  logic       cancel,
    input  logic [1:0] serviceTypeIn,
    output logic [1:0] coinInNTD_50,
    output logic [1:0] coinInNTD_10,
    output logic [1:0] coinInNTD_5,
    output logic [1:0] coinInNTD_1,
    output logic [1:0] itemTypeIn,
    output logic [1:0] refundNTD_50,
    output logic [1:0] refundNTD_10,
    output logic [1:0] refundNTD_5,
    output logic [1:0] refundNTD_1,
    output logic       refundValid,
    output logic       coinReject,
    output logic [7:0] creditValue,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_ISSUE,
        S_WAIT
    } state_t;

    localparam logic [1:0] SVC_OFF = 2'b00;
    localparam logic [1:0] SVC_ON  = 2'b01;

    state_t     state;
    logic [1:0] c50, c10, c5, c1;
    logic [1:0] n50, n10, n5, n1;
    logic [1:0] item;
    logic [1:0] sel_cnt;
    logic       collecting;
    logic       timeout;
    logic       abort;
    logic       coin_ok;
    logic       issue_on;

`ifdef COIN_TIMEOUT_EN
    logic [7:0] tcnt;

    assign timeout = (state == S_COLLECT) && !coinValid &&
                     (tcnt == TIMEOUT_CYCLES - 8'd1);

    // Counts idle COLLECT cycles; any coin or leaving COLLECT restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt <= 8'd0;
        end else if (state == S_COLLECT && !coinValid && !abort) begin
            tcnt <= tcnt + 8'd1;
        end else begin
            tcnt <= 8'd0;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    assign collecting = (state == S_IDLE) || (state == S_COLLECT);
    assign abort      = (state == S_COLLECT) && (cancel || timeout);

    always_comb begin
        sel_cnt = c1;
        unique case (coinType)
            2'b00:   sel_cnt = c50;
            2'b01:   sel_cnt = c10;
            2'b10:   sel_cnt = c5;
            default: sel_cnt = c1;
        endcase
    end

    assign coin_ok = coinValid && collecting && !abort && (sel_cnt != 2'd3);

    always_comb begin
        n50 = c50;
        n10 = c10;
        n5  = c5;
        n1  = c1;
        if (coin_ok) begin
            unique case (coinType)
                2'b00:   n50 = c50 + 2'd1;
                2'b01:   n10 = c10 + 2'd1;
                2'b10:   n5  = c5 + 2'd1;
                default: n1  = c1 + 2'd1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            {c50, c10, c5, c1} <= 8'd0;
            item         <= 2'b00;
            refundValid  <= 1'b0;
            coinReject   <= 1'b0;
            {refundNTD_50, refundNTD_10, refundNTD_5, refundNTD_1} <= 8'd0;
        end else begin
            coinReject  <= coinValid && !coin_ok;
            refundValid <= abort;
            {refundNTD_50, refundNTD_10, refundNTD_5, refundNTD_1} <=
                abort ? {c50, c10, c5, c1} : 8'd0;
            unique case (state)
                S_IDLE, S_COLLECT: begin
                    if (abort) begin
                        state <= S_IDLE;
                        {c50, c10, c5, c1} <= 8'd0;
                    end else begin
                        {c50, c10, c5, c1} <= {n50, n10, n5, n1};
                        if (itemSelValid && itemSel != 2'b00) begin
                            state <= S_ISSUE;
                            item  <= itemSel;
                        end else if (coinValid) begin
                            state <= S_COLLECT;
                        end
                    end
                end
                S_ISSUE: begin
                    if (serviceTypeIn == SVC_ON) begin
                        state <= S_WAIT;
                        {c50, c10, c5, c1} <= 8'd0;
                        item  <= 2'b00;
                    end
                end
                S_WAIT: begin
                    if (serviceTypeIn == SVC_OFF) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Downstream sees the transaction only while the machine reports ON.
    assign issue_on     = (state == S_ISSUE) && (serviceTypeIn == SVC_ON);
    assign coinInNTD_50 = issue_on ? c50 : 2'd0;
    assign coinInNTD_10 = issue_on ? c10 : 2'd0;
    assign coinInNTD_5  = issue_on ? c5 : 2'd0;
    assign coinInNTD_1  = issue_on ? c1 : 2'd0;
    assign itemTypeIn   = issue_on ? item : 2'd0;

    assign creditValue = ({6'd0, c50} * 8'd50) + ({6'd0, c10} * 8'd10) +
                         ({6'd0, c5} * 8'd5) + {6'd0, c1};
    assign busy = (state == S_ISSUE) || (state == S_WAIT);

endmodule

// File: tb/tb_coin_collector.sv
// Scoreboard bench for coin_collector; build with COIN_TIMEOUT_EN to cover auto-refund.
module tb_coin_collector;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       coinValid = 1'b0;
    logic [1:0] coinType = 2'b00;
    logic       itemSelValid = 1'b0;
    logic [1:0] itemSel = 2'b00;
    logic       cancel = 1'b0;
    logic [1:0] serviceTypeIn = 2'b00;
    logic [1:0] coinInNTD_50, coinInNTD_10, coinInNTD_5, coinInNTD_1;
    logic [1:0] itemTypeIn;
    logic [1:0] refundNTD_50, refundNTD_10, refundNTD_5, refundNTD_1;
    logic       refundValid, coinReject, busy;
    logic [7:0] creditValue;

`ifdef COIN_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    coin_collector #(.TIMEOUT_CYCLES(8'd4)) dut (
        .clk(clk), .reset(reset),
        .coinValid(coinValid), .coinType(coinType),
        .itemSelValid(itemSelValid), .itemSel(itemSel),
        .cancel(cancel), .serviceTypeIn(serviceTypeIn),
        .coinInNTD_50(coinInNTD_50), .coinInNTD_10(coinInNTD_10),
        .coinInNTD_5(coinInNTD_5), .coinInNTD_1(coinInNTD_1),
        .itemTypeIn(itemTypeIn),
        .refundNTD_50(refundNTD_50), .refundNTD_10(refundNTD_10),
        .refundNTD_5(refundNTD_5), .refundNTD_1(refundNTD_1),
        .refundValid(refundValid), .coinReject(coinReject),
        .creditValue(creditValue), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [9:0] issue_q[$];
    logic [7:0] refund_q[$];
    logic       reject_q[$];
    logic [9:0] ie;
    logic [7:0] re;
    logic       rj;

    logic [9:0]  issue_obs;
    logic [7:0]  refund_obs;
    logic [28:0] all_obs;

    assign issue_obs  = {itemTypeIn, coinInNTD_50, coinInNTD_10,
                         coinInNTD_5, coinInNTD_1};
    assign refund_obs = {refundNTD_50, refundNTD_10, refundNTD_5, refundNTD_1};
    assign all_obs    = {issue_obs, refund_obs, refundValid, coinReject,
                         creditValue, busy};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (all_obs !== 29'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h exp=0", all_obs);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (all_obs !== 29'd0) begin
            failures++;
            $display("FAIL post_reset_idle got=%0h exp=0", all_obs);
        end
    endtask

    task automatic test_purchase();
        coinValid = 1'b1;
        coinType = 2'b01; step();
        coinType = 2'b01; step();
        coinType = 2'b10; step();
        coinType = 2'b11; step();
        coinValid = 1'b0;
        @(negedge clk);
        checks++;
        if ({creditValue, busy, issue_obs} !== {8'd26, 1'b0, 10'd0}) begin
            failures++;
            $display("FAIL purchase_credit got=%0d/%0b/%0h exp=26/0/0",
                     creditValue, busy, issue_obs);
        end
        issue_q.push_back({2'b01, 2'd0, 2'd2, 2'd1, 2'd1});
        itemSelValid = 1'b1; itemSel = 2'b01; serviceTypeIn = 2'b01;
        step();
        itemSelValid = 1'b0;
        @(negedge clk);
        checks++;
        if (issue_obs === 10'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL purchase_issue_missing got=%0h busy=%0b exp=issue busy=1",
                     issue_obs, busy);
        end else begin
            ie = issue_q.pop_front();
            if (issue_obs !== ie) begin
                failures++;
                $display("FAIL purchase_issue got=%0h exp=%0h", issue_obs, ie);
            end
        end
        step();
        @(negedge clk);
        checks++;
        if ({issue_obs, busy, creditValue} !== {10'd0, 1'b1, 8'd0}) begin
            failures++;
            $display("FAIL purchase_wait got=%0h/%0b/%0d exp=0/1/0",
                     issue_obs, busy, creditValue);
        end
        serviceTypeIn = 2'b00;
        step();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL purchase_idle busy got=%0b exp=0", busy);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 4; i++) begin
            coinValid = 1'b1; coinType = 2'b00;
            reject_q.push_back(i == 3);
            step();
            @(negedge clk);
            rj = reject_q.pop_front();
            checks++;
            if (coinReject !== rj) begin
                failures++;
                $display("FAIL sat_reject[%0d] got=%0b exp=%0b", i, coinReject, rj);
            end
        end
        coinValid = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if ({coinReject, creditValue} !== {1'b0, 8'd150}) begin
            failures++;
            $display("FAIL sat_credit got=%0b/%0d exp=0/150", coinReject, creditValue);
        end
        refund_q.push_back({2'd3, 2'd0, 2'd0, 2'd0});
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        @(negedge clk);
        checks++;
        if (!refundValid) begin
            failures++;
            $display("FAIL sat_refund_missing got=0 exp=1");
        end else begin
            re = refund_q.pop_front();
            if (refund_obs !== re) begin
                failures++;
                $display("FAIL sat_refund got=%0h exp=%0h", refund_obs, re);
            end
        end
    endtask

    task automatic test_cancel();
        coinValid = 1'b1;
        coinType = 2'b00; step();
        coinType = 2'b11; step();
        refund_q.push_back({2'd1, 2'd0, 2'd0, 2'd1});
        reject_q.push_back(1'b1);
        cancel = 1'b1; coinType = 2'b10;
        itemSelValid = 1'b1; itemSel = 2'b10;
        step();
        cancel = 1'b0; coinValid = 1'b0; itemSelValid = 1'b0;
        @(negedge clk);
        checks++;
        if (!refundValid) begin
            failures++;
            $display("FAIL cancel_refund_missing got=0 exp=1");
        end else begin
            re = refund_q.pop_front();
            if (refund_obs !== re) begin
                failures++;
                $display("FAIL cancel_refund got=%0h exp=%0h", refund_obs, re);
            end
        end
        rj = reject_q.pop_front();
        checks++;
        if ({coinReject, creditValue, busy} !== {rj, 8'd0, 1'b0}) begin
            failures++;
            $display("FAIL cancel_state got=%0b/%0d/%0b exp=%0b/0/0",
                     coinReject, creditValue, busy, rj);
        end
        step();
        @(negedge clk);
        checks++;
        if ({refundValid, refund_obs, coinReject} !== 10'd0) begin
            failures++;
            $display("FAIL cancel_pulse_len got=%0b/%0h/%0b exp=0",
                     refundValid, refund_obs, coinReject);
        end
        cancel = 1'b1; coinValid = 1'b1; coinType = 2'b10;
        step();
        cancel = 1'b0; coinValid = 1'b0;
        @(negedge clk);
        checks++;
        if ({refundValid, coinReject, creditValue} !== {2'b00, 8'd5}) begin
            failures++;
            $display("FAIL cancel_idle_ignored got=%0b/%0b/%0d exp=0/0/5",
                     refundValid, coinReject, creditValue);
        end
        refund_q.push_back({2'd0, 2'd0, 2'd1, 2'd0});
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        @(negedge clk);
        checks++;
        if (!refundValid) begin
            failures++;
            $display("FAIL cancel5_refund_missing got=0 exp=1");
        end else begin
            re = refund_q.pop_front();
            if (refund_obs !== re) begin
                failures++;
                $display("FAIL cancel5_refund got=%0h exp=%0h", refund_obs, re);
            end
        end
    endtask

    task automatic test_service_busy();
        serviceTypeIn = 2'b10;
        itemSelValid = 1'b1; itemSel = 2'b11;
        coinValid = 1'b1; coinType = 2'b11;
        step();
        itemSelValid = 1'b0; coinValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            coinValid = (i == 1);
            cancel = (i == 1);
            reject_q.push_back(i == 1);
            step();
            coinValid = 1'b0; cancel = 1'b0;
            @(negedge clk);
            rj = reject_q.pop_front();
            checks++;
            if ({issue_obs, busy, coinReject, refundValid} !== {10'd0, 1'b1, rj, 1'b0}) begin
                failures++;
                $display("FAIL svc_busy_hold[%0d] got=%0h/%0b/%0b/%0b exp=0/1/%0b/0",
                         i, issue_obs, busy, coinReject, refundValid, rj);
            end
        end
        issue_q.push_back({2'b11, 2'd0, 2'd0, 2'd0, 2'd1});
        serviceTypeIn = 2'b01;
        #1;
        checks++;
        if (issue_obs === 10'd0) begin
            failures++;
            $display("FAIL svc_issue_missing got=0 exp=issue");
        end else begin
            ie = issue_q.pop_front();
            if (issue_obs !== ie) begin
                failures++;
                $display("FAIL svc_issue got=%0h exp=%0h", issue_obs, ie);
            end
        end
        step();
        serviceTypeIn = 2'b10;
        @(negedge clk);
        checks++;
        if ({issue_obs, busy, creditValue} !== {10'd0, 1'b1, 8'd0}) begin
            failures++;
            $display("FAIL svc_wait_busy got=%0h/%0b/%0d exp=0/1/0",
                     issue_obs, busy, creditValue);
        end
        serviceTypeIn = 2'b01;
        #1;
        checks++;
        if ({issue_obs, busy} !== {10'd0, 1'b1}) begin
            failures++;
            $display("FAIL svc_wait_on got=%0h/%0b exp=0/1", issue_obs, busy);
        end
        serviceTypeIn = 2'b00;
        step();
        @(negedge clk);
        checks++;
        if ({busy, creditValue} !== 9'd0) begin
            failures++;
            $display("FAIL svc_idle got=%0b/%0d exp=0/0", busy, creditValue);
        end
    endtask

    task automatic test_timeout();
        coinValid = 1'b1; coinType = 2'b10;
        step();
        coinValid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            @(negedge clk);
            checks++;
            if ({refundValid, refund_obs} !==
                ((TO_EN && k == 4) ? 9'h104 : 9'h000)) begin
                failures++;
                $display("FAIL timeout_cycle[%0d] got=%0b/%0h exp_en=%0b",
                         k, refundValid, refund_obs, TO_EN && k == 4);
            end
        end
        checks++;
        if (creditValue !== (TO_EN ? 8'd0 : 8'd5)) begin
            failures++;
            $display("FAIL timeout_credit got=%0d exp=%0d",
                     creditValue, TO_EN ? 0 : 5);
        end
`ifndef COIN_TIMEOUT_EN
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        @(negedge clk);
        checks++;
        if ({refundValid, refund_obs, creditValue} !== {1'b1, 8'h04, 8'd0}) begin
            failures++;
            $display("FAIL timeout_cleanup got=%0b/%0h/%0d exp=1/4/0",
                     refundValid, refund_obs, creditValue);
        end
`endif
    endtask

    task automatic test_reset_wait();
        coinValid = 1'b1; coinType = 2'b01;
        step();
        coinValid = 1'b0;
        issue_q.push_back({2'b01, 2'd0, 2'd1, 2'd0, 2'd0});
        itemSelValid = 1'b1; itemSel = 2'b01; serviceTypeIn = 2'b01;
        step();
        itemSelValid = 1'b0;
        @(negedge clk);
        checks++;
        if (issue_obs === 10'd0) begin
            failures++;
            $display("FAIL rw_issue_missing got=0 exp=issue");
        end else begin
            ie = issue_q.pop_front();
            if (issue_obs !== ie) begin
                failures++;
                $display("FAIL rw_issue got=%0h exp=%0h", issue_obs, ie);
            end
        end
        step();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (all_obs !== 29'd0) begin
            failures++;
            $display("FAIL rw_async_clear got=%0h exp=0", all_obs);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        serviceTypeIn = 2'b00;
        step();
        @(negedge clk);
        checks++;
        if (all_obs !== 29'd0) begin
            failures++;
            $display("FAIL rw_no_refund got=%0h exp=0", all_obs);
        end
        coinValid = 1'b1; coinType = 2'b00;
        step();
        coinValid = 1'b0;
        @(negedge clk);
        checks++;
        if ({creditValue, busy} !== {8'd50, 1'b0}) begin
            failures++;
            $display("FAIL rw_idle_coin got=%0d/%0b exp=50/0", creditValue, busy);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (creditValue !== 8'd0) begin
            failures++;
            $display("FAIL rc_async_credit got=%0d exp=0", creditValue);
        end
        step();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (all_obs !== 29'd0) begin
            failures++;
            $display("FAIL rc_no_refund got=%0h exp=0", all_obs);
        end
    endtask

    initial begin
        test_reset();
        test_purchase();
        test_saturate();
        test_cancel();
        test_service_busy();
        test_timeout();
        test_reset_wait();
        checks++;
        if (issue_q.size() + refund_q.size() + reject_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0",
                     issue_q.size() + refund_q.size() + reject_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
